// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
//   Shared definitions for the 4x4 keypad scanner: FSM state encoding,
//   matrix geometry, the controller's keypad-status address, and small
//   helpers for row strobing and column selection.
package keypad_scanner_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Address at which peripheral_controller exposes {overrun, key_valid, key_code}.
    localparam logic [7:0] KEYPAD_STATUS_ADDR = 8'h10;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_e;

    // Active-low one-hot strobe for the selected row.
    function automatic logic [NUM_ROWS-1:0] row_strobe(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Index of the lowest-numbered column that is pulled low.
    function automatic logic [1:0] lowest_low(input logic [NUM_COLS-1:0] c);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!c[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// keypad_scanner_sync2
//   Parameterised-width two-flop synchronizer (the sync2 stage for the
//   keypad column inputs). Both flops reset to all-ones so an idle,
//   pulled-up column reads as "not pressed" straight out of reset.
// Ports:
//   clk     - system clock
//   resetn  - asynchronous active-low reset
//   d_i     - asynchronous input bus
//   q_o     - synchronized output, two cycles of latency
module keypad_scanner_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Row-strobing scanner for a 4x4 matrix keypad. Walks an active-low
//   strobe across the rows, debounces one key at a time and presents the
//   accepted key with sticky valid/overrun flags for peripheral_controller.
// Ports:
//   clk       - system clock
//   resetn    - asynchronous active-low reset
//   rows      - row strobe, one-hot active-low (registered)
//   cols      - column sense, active-low, asynchronous
//   key_read  - one-cycle pulse, consumes the current key
//   key_code  - {row_idx, col_idx} of the last accepted key
//   key_valid - sticky, set on accept, cleared by key_read
//   overrun   - key accepted while key_valid was still set
//
// state       | meaning
// ST_SCAN     | strobing rows, looking for any low column
// ST_DEBOUNCE | row frozen, counting ticks with the latched column low
// ST_HELD     | key accepted, counting ticks with the column high
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                clk,
    input  logic                resetn,
    output logic [NUM_ROWS-1:0] rows,
    input  logic [NUM_COLS-1:0] cols,
    input  logic                key_read,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_COLS-1:0] cols_s;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick;
    state_e              state_q, state_d;
    logic [1:0]          row_idx_q, row_idx_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept;
    logic                col_low;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                overrun_q, overrun_d;

    keypad_scanner_sync2 #(.WIDTH(NUM_COLS)) u_cols_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (cols),
        .q_o    (cols_s)
    );

    assign tick    = (div_q == '0);
    assign div_d   = tick ? DIV_LOAD : div_q - 1'b1;
    assign col_low = ~cols_s[col_idx_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_SCAN;
        else         state_q <= state_d;
    end

    // The single count serves as press count in DEBOUNCE and release count
    // in HELD; it is zeroed on every state change into either.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (cols_s != '1) begin
                        col_idx_d = lowest_low(cols_s);
                        cnt_d     = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_low) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                        state_d   = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (!col_low) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d     = '0;
                            row_idx_d = row_idx_q + 2'd1;
                            state_d   = ST_SCAN;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // A read coinciding with an accept consumes the old key, so the new key
    // never counts as an overrun on that cycle.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        rows_d      = row_strobe(row_idx_d);
        if (accept) begin
            key_code_d  = {row_idx_q, col_idx_q};
            key_valid_d = 1'b1;
            overrun_d   = ~key_read & (overrun_q | key_valid_q);
        end else if (key_read) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q       <= DIV_LOAD;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            cnt_q       <= '0;
            rows_q      <= 4'b1110;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            cnt_q       <= cnt_d;
            rows_q      <= rows_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rows      = rows_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;

endmodule
